wb_rr_arbiter: RTL and testbench

N-master round-robin Wishbone arbiter sharing the single external memory bus between the cache memory controller and other bus masters (DMA, video fetch, debug). It grants one master per bus cycle and holds that grant while the master keeps cyc asserted, so a master can do locked multi-transfer sequences. It muxes the granted master's signals onto the slave port and routes the slave responses back to that master only. A per-transfer watchdog terminates hung transfers with err.

---
 rtl/wb_rr_arbiter.sv | 229 ++++++++++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin Wishbone arbiter for NUM_MASTERS masters and one
// shared slave bus. A master keeps the bus for as long as it holds cyc, so
// locked multi-transfer sequences are not split. The slave's request signals
// are muxed from the granted master, and responses go back to that master only.
// A per-transfer watchdog forces err on a strobe that nobody answers.
//
// Handshake: a transfer is live while s_cyc_o & s_stb_o are high. It
// completes in the cycle the slave raises exactly one of ack/err/rty.
// Responses count only while the granted master holds cyc and stb; at any
// other time (idle, stb low) they are dropped. A response seen in a cycle
// with no live request is discarded and reaches no master.
module wb_rr_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int DATA_WIDTH  = 128,
  parameter int ADDR_WIDTH  = 32,
  parameter int SEL_WIDTH   = DATA_WIDTH / 8,
  parameter int TIMEOUT     = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  // master side
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
  output logic [DATA_WIDTH-1:0]             m_dat_o,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel_i,
  input  logic [NUM_MASTERS-1:0]            m_stb_i,
  input  logic [NUM_MASTERS-1:0]            m_cyc_i,
  output logic [NUM_MASTERS-1:0]            m_ack_o,
  output logic [NUM_MASTERS-1:0]            m_err_o,
  output logic [NUM_MASTERS-1:0]            m_rty_o,
  // slave side
  output logic [ADDR_WIDTH-1:0]             s_adr_o,
  output logic [DATA_WIDTH-1:0]             s_dat_o,
  input  logic [DATA_WIDTH-1:0]             s_dat_i,
  output logic                              s_we_o,
  output logic [SEL_WIDTH-1:0]              s_sel_o,
  output logic                              s_stb_o,
  output logic                              s_cyc_o,
  input  logic                              s_ack_i,
  input  logic                              s_err_i,
  input  logic                              s_rty_i,
  // status
  output logic [NUM_MASTERS-1:0]            grant_o
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } state_t;

  // Arbiter state. g_q is the granted master. last_q is the most recent
  // winner, so the rotation puts the master just served at the back of the
  // queue. grant_q is the registered one-hot copy of g_q and reads all zero
  // when the arbiter is idle.
  state_t                 state_q;
  logic [IDX_W-1:0]       g_q;
  logic [IDX_W-1:0]       last_q;
  logic [NUM_MASTERS-1:0] grant_q;

  // Round-robin search result
  logic                   arb_found;
  logic [IDX_W-1:0]       arb_idx;
  int                     cand;
  logic [IDX_W-1:0]       cand_idx;

  // Signals of the currently granted master
  logic                   is_granted;
  logic                   cur_cyc;
  logic                   cur_stb;
  logic                   cur_we;
  logic [ADDR_WIDTH-1:0]  cur_adr;
  logic [DATA_WIDTH-1:0]  cur_dat;
  logic [SEL_WIDTH-1:0]   cur_sel;

  // Slave termination and watchdog interface
  logic                   slv_term;
  logic                   resp_ok;
  logic                   wd_fire;

  assign is_granted = (state_q == GRANTED);
  assign slv_term   = s_ack_i | s_err_i | s_rty_i;

  // Pick the first requester after last_q, wrapping modulo NUM_MASTERS. If
  // the granted master has just dropped cyc, last_q equals g_q, so that
  // master is tried last.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = last_q;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand     = (int'(last_q) + i) % NUM_MASTERS;
      cand_idx = IDX_W'(cand);
      if (!arb_found && m_cyc_i[cand_idx]) begin
        arb_found = 1'b1;
        arb_idx   = cand_idx;
      end
    end
  end

  // Select the request signals of the granted master
  always_comb begin
    cur_cyc = m_cyc_i[g_q];
    cur_stb = m_stb_i[g_q];
    cur_we  = m_we_i[g_q];
    cur_adr = m_adr_i[g_q*ADDR_WIDTH +: ADDR_WIDTH];
    cur_dat = m_dat_i[g_q*DATA_WIDTH +: DATA_WIDTH];
    cur_sel = m_sel_i[g_q*SEL_WIDTH +: SEL_WIDTH];
  end

  // Arbiter FSM: take a grant from IDLE; hold it while the owner keeps cyc
  // high; when cyc drops, hand the bus over in the same edge or go idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      g_q     <= '0;
      last_q  <= IDX_W'(NUM_MASTERS - 1);
      grant_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arb_found) begin
            state_q <= GRANTED;
            g_q     <= arb_idx;
            last_q  <= arb_idx;
            grant_q <= {{(NUM_MASTERS-1){1'b0}}, 1'b1} << arb_idx;
          end
        end
        GRANTED: begin
          if (!cur_cyc) begin
            if (arb_found) begin
              g_q     <= arb_idx;
              last_q  <= arb_idx;
              grant_q <= {{(NUM_MASTERS-1){1'b0}}, 1'b1} << arb_idx;
            end else begin
              state_q <= IDLE;
              grant_q <= '0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  // Watchdog. cnt_q counts strobe cycles in a row that had no answer. When
  // the next strobe cycle would be number TIMEOUT, fire_q is set for that
  // cycle. That cycle's strobe is withdrawn and the master gets err instead.
  // A TIMEOUT of 1 acts like 2, because the forced-err cycle is registered.
  generate
    if (TIMEOUT > 0) begin : g_wd
      localparam int CW      = $clog2(TIMEOUT + 1);
      localparam int FIRE_AT = (TIMEOUT > 1) ? TIMEOUT - 1 : 1;

      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;
      logic          fire_q;
      logic          fire_d;

      // Next count: grows on an unanswered live strobe; any other cycle
      // (termination, stb low, handover, or the fire cycle itself) clears it
      always_comb begin
        cnt_d  = '0;
        fire_d = 1'b0;
        if (is_granted && cur_cyc && cur_stb && !fire_q && !slv_term) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CW'(FIRE_AT)) begin
            fire_d = 1'b1;
          end
        end
      end

      // Watchdog registers
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_q  <= '0;
          fire_q <= 1'b0;
        end else begin
          cnt_q  <= cnt_d;
          fire_q <= fire_d;
        end
      end

      assign wd_fire = fire_q;
    end else begin : g_no_wd
      assign wd_fire = 1'b0;
    end
  endgenerate

  // Responses count only while the owner presents a transfer
  assign resp_ok = is_granted & cur_cyc & cur_stb;

  // Drive the slave port from the owner and route responses back to it only.
  // A real slave response in the watchdog cycle takes priority over the
  // forced err.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    m_rty_o = '0;
    if (is_granted) begin
      s_cyc_o      = cur_cyc;
      s_stb_o      = cur_stb & ~wd_fire;
      s_we_o       = cur_we;
      s_adr_o      = cur_adr;
      s_dat_o      = cur_dat;
      s_sel_o      = cur_sel;
      m_ack_o[g_q] = resp_ok & s_ack_i;
      m_rty_o[g_q] = resp_ok & s_rty_i;
      m_err_o[g_q] = (resp_ok & s_err_i)
                   | (wd_fire & ~(resp_ok & (s_ack_i | s_rty_i)));
    end
  end

  assign m_dat_o = s_dat_i;
  assign grant_o = grant_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter: directed scenarios plus randomized traffic for
// wb_rr_arbiter. A behavioural model follows the arbiter: the current owner,
// the rotation pointer, and the run of unanswered strobes. Every output is
// compared with the model once per cycle.
module tb_wb_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N*AW-1:0] m_adr_i = '0;
  logic [N*DW-1:0] m_dat_i = '0;
  logic [DW-1:0]   m_dat_o;
  logic [N-1:0]    m_we_i  = '0;
  logic [N*SW-1:0] m_sel_i = '0;
  logic [N-1:0]    m_stb_i = '0;
  logic [N-1:0]    m_cyc_i = '0;
  logic [N-1:0]    m_ack_o, m_err_o, m_rty_o;
  logic [AW-1:0]   s_adr_o;
  logic [DW-1:0]   s_dat_o;
  logic [DW-1:0]   s_dat_i = '0;
  logic            s_we_o;
  logic [SW-1:0]   s_sel_o;
  logic            s_stb_o, s_cyc_o;
  logic            s_ack_i = 1'b0, s_err_i = 1'b0, s_rty_i = 1'b0;
  logic [N-1:0]    grant_o;

  wb_rr_arbiter #(
    .NUM_MASTERS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SEL_WIDTH(SW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_dat_o(m_dat_o), .m_we_i(m_we_i),
    .m_sel_i(m_sel_i), .m_stb_i(m_stb_i), .m_cyc_i(m_cyc_i),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_we_o(s_we_o),
    .s_sel_o(s_sel_o), .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .grant_o(grant_o)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [N-1:0] exp_q[$];
  logic [N-1:0] got_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int   mg     = -1;  // owner, -1 when idle
  int   mlast  = N - 1;
  int   mstall = 0;   // consecutive unanswered strobe cycles
  bit   mfire  = 0;   // forced-error cycle
  bit   chk_en = 0;

  task automatic model_edge();
    if (rst) begin
      mg = -1; mlast = N - 1; mstall = 0; mfire = 0;
    end else if (mg < 0 || !m_cyc_i[mg]) begin
      mg = -1;
      for (int i = 1; i <= N; i++) begin
        int c;
        c = (mlast + i) % N;
        if (mg < 0 && m_cyc_i[c]) mg = c;
      end
      if (mg >= 0) mlast = mg;
      mstall = 0; mfire = 0;
    end else begin
      if (!mfire && m_stb_i[mg] && !(s_ack_i || s_err_i || s_rty_i)) mstall++;
      else mstall = 0;
      mfire = (mstall == TO - 1);
    end
  endtask

  task automatic compare_all();
    logic [N-1:0]  e_grant, e_ack, e_err, e_rty;
    logic          e_cyc, e_stb, e_we, ok;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_dat;
    logic [SW-1:0] e_sel;
    e_grant = '0; e_ack = '0; e_err = '0; e_rty = '0;
    e_cyc = 0; e_stb = 0; e_we = 0; e_adr = '0; e_dat = '0; e_sel = '0;
    if (mg >= 0) begin
      e_grant[mg] = 1'b1;
      e_cyc = m_cyc_i[mg];
      e_stb = m_stb_i[mg] & !mfire;
      e_we  = m_we_i[mg];
      e_adr = m_adr_i[mg*AW +: AW];
      e_dat = m_dat_i[mg*DW +: DW];
      e_sel = m_sel_i[mg*SW +: SW];
      ok = m_cyc_i[mg] & m_stb_i[mg];
      e_ack[mg] = ok & s_ack_i;
      e_rty[mg] = ok & s_rty_i;
      e_err[mg] = (ok & s_err_i) | (mfire & !(ok & (s_ack_i | s_rty_i)));
    end
    check_eq("grant", 64'(grant_o), 64'(e_grant));
    check_eq("s_cyc", 64'(s_cyc_o), 64'(e_cyc));
    check_eq("s_stb", 64'(s_stb_o), 64'(e_stb));
    check_eq("s_we",  64'(s_we_o),  64'(e_we));
    check_eq("s_adr", 64'(s_adr_o), 64'(e_adr));
    check_eq("s_dat", 64'(s_dat_o), 64'(e_dat));
    check_eq("s_sel", 64'(s_sel_o), 64'(e_sel));
    check_eq("m_ack", 64'(m_ack_o), 64'(e_ack));
    check_eq("m_err", 64'(m_err_o), 64'(e_err));
    check_eq("m_rty", 64'(m_rty_o), 64'(e_rty));
    check_eq("m_dat", 64'(m_dat_o), 64'(s_dat_i));
  endtask

  // ---------------- driver tasks ----------------
  task automatic half();
    @(negedge clk);
    if (chk_en) compare_all();
  endtask

  task automatic edge_();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cycle1();
    half();
    edge_();
  endtask

  task automatic rand_fields();
    for (int k = 0; k < N; k++) begin
      m_adr_i[k*AW +: AW] = AW'($urandom);
      m_dat_i[k*DW +: DW] = DW'($urandom);
      m_sel_i[k*SW +: SW] = SW'($urandom);
      m_we_i[k] = 1'($urandom_range(0, 1));
    end
    s_dat_i = DW'($urandom);
  endtask

  task automatic quiet();
    m_cyc_i = '0; m_stb_i = '0;
    s_ack_i = 0; s_err_i = 0; s_rty_i = 0;
  endtask

  task automatic do_reset();
    quiet();
    rst = 1'b1;
    cycle1();
    cycle1();
    rst = 1'b0;
  endtask

  int silent_left = 0;

  task automatic rand_drive();
    int r;
    rand_fields();
    for (int k = 0; k < N; k++) begin
      if (m_cyc_i[k]) begin
        if ($urandom_range(0, 9) == 0) begin
          m_cyc_i[k] = 1'b0; m_stb_i[k] = 1'b0;
        end else if ($urandom_range(0, 7) == 0) begin
          m_stb_i[k] = ~m_stb_i[k];
        end
      end else if ($urandom_range(0, 3) == 0) begin
        m_cyc_i[k] = 1'b1;
        m_stb_i[k] = 1'($urandom_range(0, 1));
      end
    end
    s_ack_i = 0; s_err_i = 0; s_rty_i = 0;
    if (silent_left > 0) begin
      silent_left--;
    end else begin
      if ($urandom_range(0, 30) == 0) silent_left = $urandom_range(5, 20);
      r = $urandom_range(0, 15);
      s_ack_i = (r < 5);
      s_err_i = (r == 5);
      s_rty_i = (r == 6);
    end
    rst = ($urandom_range(0, 299) == 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [N-1:0] acked;
    int acks;
    bit done;

    // reset: model is synchronised by the first edge, checks start after it
    quiet();
    rand_fields();
    edge_();
    chk_en = 1;
    cycle1();
    rst = 1'b0;

    // Scenario 1: single request, ack on cycle 3
    m_cyc_i = 4'b0001; m_stb_i = 4'b0001;
    half(); check_eq("t1_c0_grant", 64'(grant_o), 64'd0); edge_();
    half(); check_eq("t1_c1_grant", 64'(grant_o), 64'b0001);
    check_eq("t1_c1_scyc", 64'(s_cyc_o), 64'd1); edge_();
    half(); check_eq("t1_c2_ack", 64'(m_ack_o), 64'd0); edge_();
    s_ack_i = 1;
    half(); check_eq("t1_c3_ack", 64'(m_ack_o), 64'b0001); edge_();
    s_ack_i = 0;
    half(); check_eq("t1_c4_ack", 64'(m_ack_o), 64'd0); edge_();
    quiet(); cycle1();

    // Scenario 2: all four request, each drops cyc for one cycle after an ack
    do_reset();
    m_cyc_i = 4'b1111; m_stb_i = 4'b1111; s_ack_i = 1;
    exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    got_q = {};
    done = 0;
    for (int t = 0; t < 40 && !done; t++) begin
      half();
      acked = m_ack_o;
      if (grant_o != 0 && (got_q.size() == 0 || got_q[$] != grant_o)) got_q.push_back(grant_o);
      if (got_q.size() > 0) check_eq("t2_no_gap", 64'(grant_o != 0), 64'd1);
      if (got_q.size() >= 5) done = 1;
      edge_();
      for (int k = 0; k < N; k++) begin
        if (!m_cyc_i[k]) begin m_cyc_i[k] = 1; m_stb_i[k] = 1; end
        else if (acked[k]) begin m_cyc_i[k] = 0; m_stb_i[k] = 0; end
      end
    end
    check_eq("t2_done", 64'(done), 64'd1);
    for (int i = 0; i < 5; i++)
      check_eq("t2_order", (i < got_q.size()) ? 64'(got_q[i]) : 64'hx, 64'(exp_q[i]));
    quiet(); cycle1(); cycle1();

    // Scenario 3: master 2 keeps the bus through three transfers
    do_reset();
    m_cyc_i = 4'b0100; m_stb_i = 4'b0100;
    cycle1();
    m_cyc_i[1] = 1; m_stb_i[1] = 1;
    acks = 0;
    for (int t = 0; t < 6; t++) begin
      s_ack_i = t[0];
      half();
      check_eq("t3_hold", 64'(grant_o), 64'b0100);
      if (m_ack_o[2]) acks++;
      edge_();
    end
    check_eq("t3_acks", 64'(acks), 64'd3);
    s_ack_i = 0; m_cyc_i[2] = 0; m_stb_i[2] = 0;
    cycle1();
    half(); check_eq("t3_handover", 64'(grant_o), 64'b0010); edge_();
    quiet(); cycle1();

    // Scenario 4: slave never answers, watchdog fires on the 8th strobe cycle
    do_reset();
    m_cyc_i = 4'b0001; m_stb_i = 4'b0001;
    cycle1();
    for (int t = 1; t < TO; t++) begin
      half(); check_eq("t4_pre_err", 64'(m_err_o), 64'd0);
      check_eq("t4_pre_stb", 64'(s_stb_o), 64'd1); edge_();
    end
    half();
    check_eq("t4_fire_err", 64'(m_err_o), 64'b0001);
    check_eq("t4_fire_stb", 64'(s_stb_o), 64'd0);
    check_eq("t4_fire_ack", 64'(m_ack_o), 64'd0);
    edge_();
    half(); check_eq("t4_after_err", 64'(m_err_o), 64'd0); edge_();
    quiet(); cycle1();

    // Scenario 5: ack lands on the 8th strobe cycle and beats the watchdog
    do_reset();
    m_cyc_i = 4'b0001; m_stb_i = 4'b0001;
    cycle1();
    for (int t = 1; t < TO; t++) cycle1();
    s_ack_i = 1;
    half();
    check_eq("t5_ack", 64'(m_ack_o), 64'b0001);
    check_eq("t5_err", 64'(m_err_o), 64'd0);
    edge_();
    s_ack_i = 0;
    for (int t = 1; t < TO; t++) begin
      half(); check_eq("t5_cleared", 64'(m_err_o), 64'd0); edge_();
    end
    half(); check_eq("t5_refire", 64'(m_err_o), 64'b0001); edge_();
    quiet(); cycle1();

    // Scenario 6: reset while master 3 is in a transfer
    do_reset();
    m_cyc_i = 4'b1000; m_stb_i = 4'b1000;
    cycle1();
    half(); check_eq("t6_grant3", 64'(grant_o), 64'b1000); edge_();
    rst = 1; s_ack_i = 1;
    cycle1();
    rst = 0; m_cyc_i = 4'b1001; m_stb_i = 4'b1001; s_ack_i = 0;
    half();
    check_eq("t6_rst_grant", 64'(grant_o), 64'd0);
    check_eq("t6_rst_scyc", 64'(s_cyc_o), 64'd0);
    edge_();
    half(); check_eq("t6_first", 64'(grant_o), 64'b0001); edge_();
    quiet(); cycle1();

    // Randomized traffic against the model
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      rand_drive();
      cycle1();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
